// File: rtl/multicycle_core.sv
// Multicycle MIPS subset core: one shared ALU, one unified memory port with
// req/ready handshake, two-process control FSM and a wrapping retire counter.
module multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i,
    input  logic                mem_ready_i,
    output logic                instr_done_o,
    output logic [RETIRE_W-1:0] retire_cnt_o,
    output logic                error_o,
    output logic [31:0]         pc_o
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR = 3'b001, ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        ST_RST, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
        ST_EXEC, ST_ALUWB, ST_ADDIEX, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_ERROR
    } state_t;

    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR) || (fn == FN_SLT);
    endfunction

    function automatic logic [2:0] alu_ctl(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] ctl, input logic [31:0] x,
                                        input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        case (ctl)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {31'b0, sx < sy};
            default: return x + y;
        endcase
    endfunction

    state_t state, state_nxt;
    logic [31:0] pc, ir, mdr, a, b, alu_out;
    logic [31:0] rf [32];
    logic [RETIRE_W-1:0] retire_cnt;
    logic instr_done, retire;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sign_imm;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sign_imm = {{16{ir[15]}}, ir[15:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            ST_RST:    state_nxt = ST_FETCH;
            ST_FETCH:  if (mem_ready_i) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = ST_EXEC;
                    OP_LW, OP_SW: state_nxt = ST_MEMADR;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_ADDI:      state_nxt = ST_ADDIEX;
                    OP_J:         state_nxt = ST_JUMP;
                    default:      state_nxt = ST_ERROR;
                endcase
            end
            ST_MEMADR: state_nxt = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  if (mem_ready_i) state_nxt = ST_MEMWB;
            ST_MEMWR: begin
                if (mem_ready_i) begin
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_EXEC:   state_nxt = funct_ok(funct) ? ST_ALUWB : ST_ERROR;
            ST_ADDIEX: state_nxt = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: begin
                retire    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_ERROR;
        endcase
    end

    // Datapath registers; rf[0] is never written so it always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                ST_FETCH: if (mem_ready_i) begin
                    ir <= mem_rdata_i;
                    pc <= pc + 32'd4;
                end
                ST_DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= pc + (sign_imm << 2);
                end
                ST_MEMADR, ST_ADDIEX: alu_out <= a + sign_imm;
                ST_MEMRD:  if (mem_ready_i) mdr <= mem_rdata_i;
                ST_MEMWB:  if (rt != 5'd0) rf[rt] <= mdr;
                ST_EXEC:   alu_out <= alu(alu_ctl(funct), a, b);
                ST_ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
                ST_ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
                ST_BRANCH: if (a == b) pc <= alu_out;
                ST_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= retire;
            if (retire) retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    // Memory port is a pure decode of state and registers, so it holds while stalled.
    assign mem_req_o    = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
    assign mem_we_o     = (state == ST_MEMWR);
    assign mem_addr_o   = (state == ST_FETCH) ? pc :
                          ((state == ST_MEMRD) || (state == ST_MEMWR)) ? alu_out : 32'h0;
    assign mem_wdata_o  = (state == ST_MEMWR) ? b : 32'h0;
    assign instr_done_o = instr_done;
    assign retire_cnt_o = retire_cnt;
    assign error_o      = (state == ST_ERROR);
    assign pc_o         = pc;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: memory responder with wait states, ISA-level
// reference model for random programs, vector table and directed sequences.
module tb_multicycle_core;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, instr_done, error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [15:0] retire_cnt;
    logic        s_req, s_we, s_ready, s_done, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata, s_pc;
    logic [3:0]  s_cnt;

    multicycle_core #(.RESET_PC(RST_PC), .RETIRE_W(16)) dut (
        .clk(clk), .reset(reset), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .instr_done_o(instr_done), .retire_cnt_o(retire_cnt),
        .error_o(error), .pc_o(pc));

    multicycle_core #(.RESET_PC(RST_PC), .RETIRE_W(4)) dut_small (
        .clk(clk), .reset(reset), .mem_req_o(s_req), .mem_we_o(s_we),
        .mem_addr_o(s_addr), .mem_wdata_o(s_wdata), .mem_rdata_i(s_rdata),
        .mem_ready_i(s_ready), .instr_done_o(s_done), .retire_cnt_o(s_cnt),
        .error_o(s_err), .pc_o(s_pc));

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [5:0] funct; logic [31:0] a; logic [31:0] b; logic [31:0] exp; string name; } vec_t;

    logic [31:0] mem [0:255];
    wr_t         stores[$];
    logic [31:0] reads[$];
    int          done_cycs[$];
    logic [15:0] cnt_hist [0:1023];
    int  cyc = 0, first_req = -1, wcnt = 0, wtarget = 0, wmode = 0;
    int  stable_bad = 0, stable_checks = 0, s_dones = 0;
    logic hold_valid = 1'b0, hold_we;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0] s_snap16, s_snap17;
    int n_pass = 0, n_total = 0;

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] f);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
    endfunction
    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] ref_alu(logic [5:0] f, logic [31:0] x, logic [31:0] y);
        case (f)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] read_at(int i);
        return (i < reads.size()) ? reads[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic load_prog(input logic [31:0] prog[$]);
        for (int i = 0; i < prog.size(); i++) mem[64 + i] = prog[i];
    endtask

    task automatic do_reset(input bit check_outs);
        reset = 1'b0;
        @(posedge clk); #1;
        if (check_outs) begin
            chk("rst_req", {31'b0, mem_req}, 32'h0);
            chk("rst_we", {31'b0, mem_we}, 32'h0);
            chk("rst_addr", mem_addr, 32'h0);
            chk("rst_wdata", mem_wdata, 32'h0);
            chk("rst_done", {31'b0, instr_done}, 32'h0);
            chk("rst_cnt", {16'b0, retire_cnt}, 32'h0);
            chk("rst_error", {31'b0, error}, 32'h0);
            chk("rst_pc", pc, RST_PC);
        end
        repeat (2) @(posedge clk);
        #1;
        stores.delete(); reads.delete(); done_cycs.delete();
        cyc = 0; first_req = -1; wcnt = 0;
        wtarget = (wmode < 0) ? int'($urandom_range(3)) : wmode;
        stable_bad = 0; stable_checks = 0; hold_valid = 1'b0; s_dones = 0;
        reset = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_stores(input string name, input int n, input int budget);
        int k = 0;
        while (stores.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        chk({name, "_timeout"}, {31'b0, stores.size() >= n}, 32'h1);
    endtask

    // Memory responder and monitors: sample on the falling edge, then drive.
    initial begin
        mem_ready = 1'b0; mem_rdata = 32'h0; s_ready = 1'b1; s_rdata = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (cyc < 1024) cnt_hist[cyc] = retire_cnt;
                if (instr_done) done_cycs.push_back(cyc);
                if (mem_req && first_req < 0) first_req = cyc;
                if (s_done) begin
                    s_dones++;
                    if (s_dones == 16) s_snap16 = s_cnt;
                    if (s_dones == 17) s_snap17 = s_cnt;
                end
                if (hold_valid) begin
                    stable_checks++;
                    if (!mem_req || mem_addr !== hold_addr || mem_we !== hold_we ||
                        mem_wdata !== hold_wdata) stable_bad++;
                end
            end
            hold_valid = 1'b0;
            if (!mem_req) begin
                mem_ready = 1'($urandom);
                mem_rdata = $urandom;
            end else if (wcnt < wtarget) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
                hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
                hold_valid = 1'b1;
            end else begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    stores.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem[mem_addr[9:2]];
                    reads.push_back(mem_addr);
                end
                wcnt = 0;
                wtarget = (wmode < 0) ? int'($urandom_range(3)) : wmode;
            end
            s_rdata = s_req ? mem[s_addr[9:2]] : 32'h0;
            s_ready = 1'b1;
        end
    end

    task automatic run_random(input int idx);
        logic [31:0] prog[$];
        logic [31:0] regs [0:7];
        logic [31:0] dm [0:63];
        wr_t exp_st[$];
        logic [5:0] fns [0:4];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_mem();
        for (int w = 0; w < 64; w++) begin
            mem[w] = (w < 32) ? $urandom : 32'h0;
            dm[w] = mem[w];
        end
        for (int r = 0; r < 8; r++) regs[r] = 32'h0;
        for (int i = 0; i < 16; i++) begin
            int kind = $urandom_range(7);
            int rs = $urandom_range(7), rt = $urandom_range(7), rd = $urandom_range(7);
            int w = $urandom_range(31);
            logic [15:0] imm = 16'($urandom);
            logic [5:0] f = fns[$urandom_range(4)];
            logic [31:0] v;
            if (kind == 0) begin
                prog.push_back(enc_i(6'h08, rs, rt, imm));
                v = regs[rs] + {{16{imm[15]}}, imm};
                if (rt != 0) regs[rt] = v;
            end else if (kind == 6) begin
                prog.push_back(enc_i(6'h23, 0, rt, 16'(w * 4)));
                if (rt != 0) regs[rt] = dm[w];
            end else if (kind == 7) begin
                prog.push_back(enc_i(6'h2B, 0, rt, 16'(w * 4)));
                dm[w] = regs[rt];
                exp_st.push_back({32'(w * 4), regs[rt]});
            end else begin
                prog.push_back(enc_r(rs, rt, rd, f));
                v = ref_alu(f, regs[rs], regs[rt]);
                if (rd != 0) regs[rd] = v;
            end
        end
        for (int r = 1; r < 8; r++) begin
            prog.push_back(enc_i(6'h2B, 0, r, 16'(32'h80 + 4 * r)));
            exp_st.push_back({32'h80 + 32'(4 * r), regs[r]});
        end
        prog.push_back(enc_i(6'h04, 0, 0, 16'hFFFF));
        load_prog(prog);
        wmode = -1;
        do_reset(1'b0);
        wait_stores($sformatf("rand%0d", idx), exp_st.size(), 4000);
        for (int i = 0; i < exp_st.size(); i++) begin
            wr_t got = (i < stores.size()) ? stores[i] : {32'hBAD0_BAD0, 32'hBAD0_BAD0};
            chk($sformatf("rand%0d_st%0d_addr", idx, i), got.addr, exp_st[i].addr);
            chk($sformatf("rand%0d_st%0d_data", idx, i), got.data, exp_st[i].data);
        end
        chk($sformatf("rand%0d_error", idx), {31'b0, error}, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [10];
        logic [31:0] p[$];
        int n_in;
        vecs[0] = '{6'h20, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_wrap"};
        vecs[1] = '{6'h20, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_ovf"};
        vecs[2] = '{6'h22, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_under"};
        vecs[3] = '{6'h22, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, "sub_ovf"};
        vecs[4] = '{6'h24, 32'hF0F0_FFFF, 32'h0FF0_1234, 32'h00F0_1234, "and"};
        vecs[5] = '{6'h25, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or"};
        vecs[6] = '{6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg"};
        vecs[7] = '{6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_pos"};
        vecs[8] = '{6'h2A, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, "slt_min"};
        vecs[9] = '{6'h2A, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, "slt_eq"};
        #2;

        // ALU sequence, reset state and startup timing
        clear_mem();
        p = '{enc_i(6'h08, 0, 2, 16'd5), enc_i(6'h08, 0, 3, 16'd12), enc_r(3, 2, 4, 6'h22),
              enc_r(2, 3, 5, 6'h2A), enc_i(6'h2B, 0, 4, 16'h40), enc_i(6'h04, 0, 0, 16'hFFFF)};
        load_prog(p);
        wmode = 0;
        do_reset(1'b1);
        wait_cycles(30);
        chk("start_first_req", {31'b0, (first_req == 2) || (first_req == 3)}, 32'h1);
        chk("alu_store_cnt", stores.size(), 32'd1);
        chk("alu_store_addr", (stores.size() > 0) ? stores[0].addr : 32'hBAD0_BAD0, 32'h40);
        chk("alu_store_data", (stores.size() > 0) ? stores[0].data : 32'hBAD0_BAD0, 32'd7);
        chk("alu_cnt_at19", {16'b0, cnt_hist[first_req + 19]}, 32'd4);
        chk("alu_cnt_at20", {16'b0, cnt_hist[first_req + 20]}, 32'd5);
        chk("fetch0", read_at(0), 32'h100);
        chk("fetch4", read_at(4), 32'h110);
        chk("beq_loop_a", read_at(5), 32'h114);
        chk("beq_loop_b", read_at(6), 32'h114);

        // Three wait states on every request of a load
        clear_mem();
        mem[16] = 32'd7;
        p = '{enc_i(6'h23, 0, 6, 16'h40), enc_i(6'h2B, 0, 6, 16'h44), enc_i(6'h04, 0, 0, 16'hFFFF)};
        load_prog(p);
        wmode = 3;
        do_reset(1'b0);
        wait_stores("wait", 1, 200);
        chk("wait_lw_cycles", (done_cycs.size() > 0) ? done_cycs[0] - first_req : -1, 32'd11);
        n_in = 0;
        foreach (done_cycs[i]) if (done_cycs[i] <= first_req + 11) n_in++;
        chk("wait_one_done", n_in, 32'd1);
        chk("wait_lw_value", (stores.size() > 0) ? stores[0].data : 32'hBAD0_BAD0, 32'd7);
        chk("wait_store_addr", (stores.size() > 0) ? stores[0].addr : 32'hBAD0_BAD0, 32'h44);
        chk("wait_stable", stable_bad, 32'd0);
        chk("wait_stalls_seen", {31'b0, stable_checks > 0}, 32'h1);

        // Control flow: $0 write, beq not taken / taken forward, jump
        clear_mem();
        mem[4] = 32'hDEAD;
        p = '{enc_i(6'h08, 0, 0, 16'd9), enc_i(6'h08, 0, 1, 16'd1), enc_i(6'h04, 1, 0, 16'd5),
              enc_i(6'h2B, 0, 0, 16'h10), enc_i(6'h04, 0, 0, 16'd1), 32'hFC00_0000,
              {6'h02, 26'h0000040}};
        load_prog(p);
        wmode = -1;
        do_reset(1'b0);
        wait_stores("ctl", 1, 300);
        wait_cycles(40);
        chk("r0_reads_zero", (stores.size() > 0) ? stores[0].data : 32'hBAD0_BAD0, 32'h0);
        chk("beq_not_taken", read_at(3), 32'h10C);
        chk("beq_fwd_taken", read_at(5), 32'h118);
        chk("jump_target", read_at(6), 32'h100);
        chk("jump_loop", read_at(7), 32'h104);
        chk("ctl_error", {31'b0, error}, 32'h0);

        // ALU vector table
        foreach (vecs[i]) begin
            clear_mem();
            mem[0] = vecs[i].a;
            mem[1] = vecs[i].b;
            p = '{enc_i(6'h23, 0, 1, 16'h0), enc_i(6'h23, 0, 2, 16'h4), enc_r(1, 2, 3, vecs[i].funct),
                  enc_i(6'h2B, 0, 3, 16'h8), enc_i(6'h04, 0, 0, 16'hFFFF)};
            load_prog(p);
            wmode = -1;
            do_reset(1'b0);
            wait_stores(vecs[i].name, 1, 300);
            chk(vecs[i].name, (stores.size() > 0) ? stores[0].data : 32'hBAD0_BAD0, vecs[i].exp);
        end

        for (int r = 0; r < 3; r++) run_random(r);

        // Unsupported opcode, then reset clears the error
        clear_mem();
        p = '{enc_i(6'h08, 0, 1, 16'd1), 32'hFC00_0000, enc_i(6'h2B, 0, 1, 16'h10)};
        load_prog(p);
        wmode = 0;
        do_reset(1'b0);
        wait_cycles(40);
        chk("err_set", {31'b0, error}, 32'h1);
        chk("err_cnt", {16'b0, retire_cnt}, 32'd1);
        chk("err_fetches", reads.size(), 32'd2);
        chk("err_no_req", {31'b0, mem_req}, 32'h0);
        chk("err_no_store", stores.size(), 32'd0);
        do_reset(1'b1);

        // Counter wrap on the 4-bit instance
        clear_mem();
        p = '{enc_i(6'h04, 0, 0, 16'hFFFF)};
        load_prog(p);
        wmode = 0;
        do_reset(1'b0);
        for (int k = 0; k < 300 && s_dones < 17; k++) wait_cycles(1);
        chk("wrap_reached", {31'b0, s_dones >= 17}, 32'h1);
        chk("wrap_16", {28'b0, s_snap16}, 32'd0);
        chk("wrap_17", {28'b0, s_snap17}, 32'd1);
        chk("wrap_err", {31'b0, s_err}, 32'h0);
        chk("wrap_no_we", {31'b0, s_we}, 32'h0);
        chk("wrap_wdata", s_wdata, 32'h0);
        chk("wrap_pc_range", {31'b0, (s_pc == 32'h100) || (s_pc == 32'h104)}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
